// File: rtl/jtag_tdo_axis_pkg.sv
// Shared types and constants for the JTAG TDO to AXI-Stream packer.
// Packer state, keep encodings and the 73-bit FIFO entry layout.
package jtag_axis_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    localparam logic [7:0] KEEP_FULL = 8'hFF;
    localparam logic [7:0] KEEP_LOW  = 8'h0F;
    localparam logic [7:0] KEEP_NULL = 8'h00;

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } axis_word_t;

endpackage

// File: rtl/jtag_tdo_axis_if.sv
// AXI-Stream master bus carrying packed TDO words.
// The producer uses the master modport, the sink the slave modport.
interface jtag_tdo_axis_if;

    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [7:0]  tkeep;
    logic        tlast;

    modport master (
        output tdata,
        output tvalid,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tkeep,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_word_fifo.sv
// Show-ahead FIFO of {tlast, tkeep, tdata} entries.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module axis_word_fifo
    import jtag_axis_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  axis_word_t                 push_word,
    output logic                       accepted,
    input  logic                       pop,
    output axis_word_t                 head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          pop_ok;
    axis_word_t    mem [DEPTH];

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign pop_ok   = pop && !empty;
    assign accepted = push && (!full || pop_ok);
    assign level    = cnt;
    assign head     = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are masked by empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (accepted) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (accepted) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({accepted, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/jtag_tdo_axis.sv
// Packs pairs of 32-bit TDO captures into 64-bit AXI-Stream words.
// Handles flush, automatic packet end and sticky overflow on drops.
module jtag_tdo_axis
    import jtag_axis_pkg::*;
#(
    parameter int C_TDO_WIDTH  = 32,
    parameter int C_FIFO_DEPTH = 4,
    parameter int C_PKT_WORDS  = 16
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_aresetn,
    input  logic                          done,
    input  logic [C_TDO_WIDTH-1:0]        tdo_vector,
    input  logic                          flush,
    jtag_tdo_axis_if.master               m_axis,
    output logic                          overflow,
    output logic [$clog2(C_FIFO_DEPTH):0] fifo_level
);

    localparam int CNT_W = $clog2(C_PKT_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_PKT_WORDS - 1);

    pack_state_t            state_q;
    pack_state_t            state_d;
    logic [C_TDO_WIDTH-1:0] held_q;
    logic [C_TDO_WIDTH-1:0] held_d;
    logic [CNT_W-1:0]       pkt_cnt_q;
    logic                   overflow_q;

    logic                   push;
    logic                   close;
    axis_word_t             push_word;
    logic                   accepted;
    logic                   pop;
    axis_word_t             head;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Next-state and push word selection for the half-word packer.
    always_comb begin
        state_d        = state_q;
        held_d         = held_q;
        push           = 1'b0;
        close          = 1'b0;
        push_word      = '0;
        push_word.keep = KEEP_NULL;
        unique case (state_q)
            EMPTY: begin
                if (done && flush) begin
                    push           = 1'b1;
                    close          = 1'b1;
                    push_word.data = {{C_TDO_WIDTH{1'b0}}, tdo_vector};
                    push_word.keep = KEEP_LOW;
                end else if (done) begin
                    held_d  = tdo_vector;
                    state_d = HALF;
                end else if (flush && pkt_cnt_q != '0) begin
                    push  = 1'b1;
                    close = 1'b1;
                end
            end
            HALF: begin
                if (done) begin
                    push           = 1'b1;
                    close          = flush;
                    push_word.data = {tdo_vector, held_q};
                    push_word.keep = KEEP_FULL;
                    state_d        = EMPTY;
                end else if (flush) begin
                    push           = 1'b1;
                    close          = 1'b1;
                    push_word.data = {{C_TDO_WIDTH{1'b0}}, held_q};
                    push_word.keep = KEEP_LOW;
                    state_d        = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        push_word.last = close || (pkt_cnt_q == CNT_LAST);
    end

    // Packer state and held low half.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q <= EMPTY;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    // Packet word counter advances only on accepted pushes.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            pkt_cnt_q <= '0;
        end else if (accepted) begin
            pkt_cnt_q <= push_word.last ? '0 : pkt_cnt_q + 1'b1;
        end
    end

    // Sticky drop indicator, cleared only by reset.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            overflow_q <= 1'b0;
        end else if (push && !accepted) begin
            overflow_q <= 1'b1;
        end
    end

    assign pop = m_axis.tvalid && m_axis.tready;

    axis_word_fifo #(
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk       (s_axis_aclk),
        .rst_n     (s_axis_aresetn),
        .push      (push),
        .push_word (push_word),
        .accepted  (accepted),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = head.data;
    assign m_axis.tkeep  = head.keep;
    assign m_axis.tlast  = head.last;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_jtag_tdo_axis.sv
// Self-checking bench for jtag_tdo_axis against a queue-based model.
// Directed scenarios followed by randomized traffic.
module tb_jtag_tdo_axis;

    localparam int DEPTH = 4;
    localparam int PKT   = 2;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        done   = 1'b0;
    logic        flush  = 1'b0;
    logic [31:0] tdo    = '0;
    logic        ovf;
    logic [2:0]  level;

    jtag_tdo_axis_if m_axis ();

    jtag_tdo_axis #(
        .C_TDO_WIDTH  (32),
        .C_FIFO_DEPTH (DEPTH),
        .C_PKT_WORDS  (PKT)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .done           (done),
        .tdo_vector     (tdo),
        .flush          (flush),
        .m_axis         (m_axis),
        .overflow       (ovf),
        .fifo_level     (level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    bit          m_has_half;
    logic [31:0] m_half;
    int          m_cnt;
    logic [72:0] m_q [$];
    bit          m_ovf;

    task automatic chk(string tag, logic [72:0] got, logic [72:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [72:0] word_of(bit last, logic [7:0] keep, logic [63:0] data);
        return {last, keep, data};
    endfunction

    function automatic logic [72:0] dut_word();
        return {m_axis.tlast, m_axis.tkeep, m_axis.tdata};
    endfunction

    task automatic model_clear();
        m_has_half = 0;
        m_half     = '0;
        m_cnt      = 0;
        m_q.delete();
        m_ovf      = 0;
    endtask

    // One clock of the reference behaviour, using the inputs about to be sampled.
    task automatic model_edge(bit d, logic [31:0] v, bit f, bit r);
        bit          pop;
        bit          push;
        bit          close;
        bit          last;
        logic [7:0]  keep;
        logic [63:0] data;
        pop   = (m_q.size() > 0) && r;
        push  = 0;
        close = 0;
        keep  = 8'h00;
        data  = '0;
        if (m_has_half) begin
            if (d) begin
                push = 1; close = f; keep = 8'hFF; data = {v, m_half};
                m_has_half = 0;
            end else if (f) begin
                push = 1; close = 1; keep = 8'h0F; data = {32'h0, m_half};
                m_has_half = 0;
            end
        end else begin
            if (d && f) begin
                push = 1; close = 1; keep = 8'h0F; data = {32'h0, v};
            end else if (d) begin
                m_has_half = 1; m_half = v;
            end else if (f && m_cnt > 0) begin
                push = 1; close = 1;
            end
        end
        last = close || (m_cnt == PKT - 1);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(word_of(last, keep, data));
                m_cnt = last ? 0 : m_cnt + 1;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("tvalid", 73'(m_axis.tvalid), 73'(m_q.size() > 0));
        chk("level", 73'(level), 73'(m_q.size()));
        chk("overflow", 73'(ovf), 73'(m_ovf));
        if (m_q.size() > 0) chk("word", dut_word(), m_q[0]);
    endtask

    task automatic step(bit d, logic [31:0] v, bit f, bit r);
        done          = d;
        tdo           = v;
        flush         = f;
        m_axis.tready = r;
        model_edge(d, v, f, r);
        @(posedge clk);
        #1;
        done  = 1'b0;
        flush = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        done          = 1'b0;
        flush         = 1'b0;
        m_axis.tready = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("rst_tvalid", 73'(m_axis.tvalid), 73'(0));
        chk("rst_level", 73'(level), 73'(0));
        chk("rst_word", dut_word(), 73'(0));
        chk("rst_overflow", 73'(ovf), 73'(0));
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        m_axis.tready = 1'b0;
        model_clear();
        #2;
        do_reset();

        // Pairing
        step(1, 32'h11111111, 0, 1);
        step(1, 32'h22222222, 0, 1);
        chk("pair", dut_word(), word_of(0, 8'hFF, 64'h2222222211111111));
        step(0, 0, 0, 1);

        // Flush on odd count
        do_reset();
        step(1, 32'hA5A5A5A5, 0, 1);
        step(0, 0, 1, 1);
        chk("flush_odd", dut_word(), word_of(1, 8'h0F, 64'h00000000A5A5A5A5));
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        chk("flush_idle", 73'(m_axis.tvalid), 73'(0));

        // Automatic tlast
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, 0);
        chk("auto_lvl", 73'(level), 73'(2));
        chk("auto_w0", dut_word(), word_of(0, 8'hFF, 64'h0000000200000001));
        step(0, 0, 0, 1);
        chk("auto_w1", dut_word(), word_of(1, 8'hFF, 64'h0000000400000003));
        step(0, 0, 0, 1);

        // Null word after a packet with pending count
        do_reset();
        step(1, 32'h5, 0, 1);
        step(1, 32'h6, 0, 1);
        step(0, 0, 1, 1);
        chk("null_word", dut_word(), word_of(1, 8'h00, 64'h0));
        step(0, 0, 0, 1);

        // Overflow
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 32'h100 + 32'(i), 0, 0);
        chk("ovf_lvl", 73'(level), 73'(4));
        chk("ovf_flag", 73'(ovf), 73'(1));
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

        // Simultaneous done and flush in HALF
        do_reset();
        step(1, 32'hDEADBEEF, 0, 1);
        step(1, 32'hCAFEF00D, 1, 1);
        chk("simul", dut_word(), word_of(1, 8'hFF, 64'hCAFEF00DDEADBEEF));
        step(0, 0, 0, 1);

        // Reset mid-packet
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 32'hF0 + 32'(i), 0, 0);
        do_reset();
        step(1, 32'h1, 0, 1);
        step(1, 32'h2, 0, 1);
        chk("post_rst", dut_word(), word_of(0, 8'hFF, 64'h0000000200000001));
        step(0, 0, 0, 1);
        chk("post_rst_empty", 73'(m_axis.tvalid), 73'(0));

        // Random traffic, mostly draining
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 60), $urandom(),
                 ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 75));
        end

        // Random traffic with heavy backpressure
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) < 50), $urandom(),
                 ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30));
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
